// File: rtl/max3421_spi_arbiter.sv
// Round-robin arbiter sharing one MAX3421 SPI link between the init sequencer (req0)
// and the interrupt poller (req1); drives the write/read engines and muxes their pins.
module max3421_spi_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [1:0]  req_valid_in,
    input  logic [1:0]  req_write_in,
    input  logic [9:0]  req_addr_in,
    input  logic [15:0] req_data_in,
    output logic [1:0]  req_ready_out,
    output logic [1:0]  resp_valid_out,
    output logic [7:0]  resp_data_out,
    output logic        resp_err_out,
    output logic [15:0] wr_msg_out,
    output logic        wr_valid_out,
    input  logic        wr_done_in,
    input  logic        wr_n_ss_in,
    input  logic        wr_mosi_in,
    input  logic        wr_sclk_in,
    output logic [8:0]  rd_msg_out,
    output logic        rd_valid_out,
    input  logic        rd_valid_in,
    input  logic [7:0]  rd_byte_in,
    input  logic        rd_n_ss_in,
    input  logic        rd_mosi_in,
    input  logic        rd_sclk_in,
    output logic        n_ss_out,
    output logic        mosi_out,
    output logic        sclk_out,
    output logic        busy_out
);

    localparam int unsigned TIMER_W = 8;
    localparam logic [TIMER_W-1:0] TIMEOUT = TIMER_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE, WR_START, WR_WAIT, RD_START, RD_WAIT, RESP
    } state_e;

    state_e             state_q, state_d;
    logic               rr_last_q, rr_last_d;
    logic               gnt_q, gnt_d;
    logic [1:0]         ready_q, ready_d;
    logic [1:0]         resp_valid_q, resp_valid_d;
    logic [7:0]         resp_data_q, resp_data_d;
    logic               resp_err_q, resp_err_d;
    logic [15:0]        wr_msg_q, wr_msg_d;
    logic               wr_valid_q, wr_valid_d;
    logic [8:0]         rd_msg_q, rd_msg_d;
    logic               rd_valid_q, rd_valid_d;
    logic               busy_q, busy_d;
    logic [TIMER_W-1:0] timer_q, timer_d;

    logic               g_c;
    logic [4:0]         addr_c;
    logic [7:0]         data_c;
    logic               wr_c;
    logic [7:0]         cmd_c;
    logic [1:0]         gnt_oh_c;

    // Engines shift bit 0 first while the MAX3421 expects MSB first.
    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // Round-robin pick and the winner's command fields.
    always_comb begin
        g_c      = (req_valid_in == 2'b11) ? ~rr_last_q : req_valid_in[1];
        addr_c   = g_c ? req_addr_in[9:5] : req_addr_in[4:0];
        data_c   = g_c ? req_data_in[15:8] : req_data_in[7:0];
        wr_c     = g_c ? req_write_in[1] : req_write_in[0];
        cmd_c    = {addr_c, 1'b0, wr_c, 1'b0};
        gnt_oh_c = gnt_q ? 2'b10 : 2'b01;
    end

    always_comb begin
        state_d      = state_q;
        rr_last_d    = rr_last_q;
        gnt_d        = gnt_q;
        ready_d      = 2'b00;
        resp_valid_d = 2'b00;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        wr_msg_d     = wr_msg_q;
        wr_valid_d   = wr_valid_q;
        rd_msg_d     = rd_msg_q;
        rd_valid_d   = rd_valid_q;
        busy_d       = busy_q;
        timer_d      = timer_q;
        case (state_q)
            IDLE: begin
                if (|req_valid_in) begin
                    ready_d   = g_c ? 2'b10 : 2'b01;
                    gnt_d     = g_c;
                    rr_last_d = g_c;
                    busy_d    = 1'b1;
                    if (wr_c) begin
                        wr_msg_d = {rev8(data_c), rev8(cmd_c)};
                        state_d  = WR_START;
                    end else begin
                        rd_msg_d = {1'b0, rev8(cmd_c)};
                        state_d  = RD_START;
                    end
                end
            end
            WR_START: begin
                wr_valid_d = 1'b1;
                timer_d    = '0;
                state_d    = WR_WAIT;
            end
            RD_START: begin
                rd_valid_d = 1'b1;
                timer_d    = '0;
                state_d    = RD_WAIT;
            end
            WR_WAIT: begin
                if (wr_done_in || timer_q == TIMEOUT) begin
                    wr_valid_d   = 1'b0;
                    resp_data_d  = 8'h00;
                    resp_err_d   = ~wr_done_in;
                    resp_valid_d = gnt_oh_c;
                    state_d      = RESP;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            RD_WAIT: begin
                if (rd_valid_in || timer_q == TIMEOUT) begin
                    rd_valid_d   = 1'b0;
                    resp_data_d  = rd_valid_in ? rd_byte_in : 8'h00;
                    resp_err_d   = ~rd_valid_in;
                    resp_valid_d = gnt_oh_c;
                    state_d      = RESP;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            RESP: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= IDLE;
            rr_last_q    <= 1'b1;
            gnt_q        <= 1'b0;
            ready_q      <= 2'b00;
            resp_valid_q <= 2'b00;
            resp_data_q  <= 8'h00;
            resp_err_q   <= 1'b0;
            wr_msg_q     <= 16'h0000;
            wr_valid_q   <= 1'b0;
            rd_msg_q     <= 9'h000;
            rd_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            rr_last_q    <= rr_last_d;
            gnt_q        <= gnt_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            wr_msg_q     <= wr_msg_d;
            wr_valid_q   <= wr_valid_d;
            rd_msg_q     <= rd_msg_d;
            rd_valid_q   <= rd_valid_d;
            busy_q       <= busy_d;
            timer_q      <= timer_d;
        end
    end

    assign req_ready_out  = ready_q;
    assign resp_valid_out = resp_valid_q;
    assign resp_data_out  = resp_data_q;
    assign resp_err_out   = resp_err_q;
    assign wr_msg_out     = wr_msg_q;
    assign wr_valid_out   = wr_valid_q;
    assign rd_msg_out     = rd_msg_q;
    assign rd_valid_out   = rd_valid_q;
    assign busy_out       = busy_q;

    // Idle engines hold n_ss high and sclk low, so AND/OR merging is glitch-free.
    assign n_ss_out = wr_n_ss_in & rd_n_ss_in;
    assign sclk_out = wr_sclk_in | rd_sclk_in;
    assign mosi_out = (state_q == RD_START || state_q == RD_WAIT) ? rd_mosi_in : wr_mosi_in;

endmodule

// File: tb/tb_max3421_spi_arbiter.sv
// Scoreboard bench for max3421_spi_arbiter: randomized requesters and engine models,
// a reference grant/response model, and a monitor comparing every DUT response.
module tb_max3421_spi_arbiter;

    localparam int unsigned TO = 20;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [1:0]  req_valid_in, req_write_in, req_ready_out, resp_valid_out;
    logic [9:0]  req_addr_in;
    logic [15:0] req_data_in, wr_msg_out;
    logic [7:0]  resp_data_out, rd_byte_in;
    logic        resp_err_out, wr_valid_out, wr_done_in, wr_n_ss_in, wr_mosi_in, wr_sclk_in;
    logic [8:0]  rd_msg_out;
    logic        rd_valid_out, rd_valid_in, rd_n_ss_in, rd_mosi_in, rd_sclk_in;
    logic        n_ss_out, mosi_out, sclk_out, busy_out;

    max3421_spi_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .req_valid_in(req_valid_in), .req_write_in(req_write_in),
        .req_addr_in(req_addr_in), .req_data_in(req_data_in),
        .req_ready_out(req_ready_out), .resp_valid_out(resp_valid_out),
        .resp_data_out(resp_data_out), .resp_err_out(resp_err_out),
        .wr_msg_out(wr_msg_out), .wr_valid_out(wr_valid_out), .wr_done_in(wr_done_in),
        .wr_n_ss_in(wr_n_ss_in), .wr_mosi_in(wr_mosi_in), .wr_sclk_in(wr_sclk_in),
        .rd_msg_out(rd_msg_out), .rd_valid_out(rd_valid_out), .rd_valid_in(rd_valid_in),
        .rd_byte_in(rd_byte_in), .rd_n_ss_in(rd_n_ss_in), .rd_mosi_in(rd_mosi_in),
        .rd_sclk_in(rd_sclk_in), .n_ss_out(n_ss_out), .mosi_out(mosi_out),
        .sclk_out(sclk_out), .busy_out(busy_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int         idx;
        bit         wr;
        logic [4:0] addr;
        logic [7:0] data;
        logic [7:0] rdata;
        bit         err;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    bit          wr_hang = 1'b0;
    int          rd_len_force = 0;
    logic [7:0]  regfile[32];
    logic [15:0] last_wr_msg = '0;
    logic [8:0]  last_rd_msg = '0;
    logic [7:0]  last_resp_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference helpers: MSB-first byte becomes LSB-first message by peeling bits off.
    function automatic logic [7:0] rev8(input logic [7:0] v);
        int x, r;
        x = int'(v);
        r = 0;
        for (int i = 0; i < 8; i++) begin
            r = r * 2 + x % 2;
            x = x / 2;
        end
        return 8'(r);
    endfunction

    function automatic logic [7:0] cmd_of(input logic [4:0] a, input bit wr);
        return 8'(int'(a) * 8 + (wr ? 2 : 0));
    endfunction

    // Write engine model: frame of random length, then a one-cycle done pulse.
    initial begin : wr_engine
        int len;
        wr_done_in = 1'b0; wr_n_ss_in = 1'b1; wr_sclk_in = 1'b0;
        forever begin
            @(posedge clk_in); #1;
            if (rst_n_in && wr_valid_out && !wr_hang) begin
                len = $urandom_range(4, 12);
                wr_n_ss_in = 1'b0;
                for (int k = 0; k < len && rst_n_in; k++) begin
                    @(posedge clk_in); #1;
                    wr_sclk_in = ~wr_sclk_in;
                end
                wr_sclk_in = 1'b0; wr_n_ss_in = 1'b1;
                if (rst_n_in) begin
                    wr_done_in = 1'b1;
                    @(posedge clk_in); #1;
                    wr_done_in = 1'b0;
                end
            end
        end
    end

    // Read engine model: decodes the address from the message and returns regfile data.
    initial begin : rd_engine
        int len;
        logic [7:0] c;
        rd_valid_in = 1'b0; rd_n_ss_in = 1'b1; rd_sclk_in = 1'b0; rd_byte_in = 8'h00;
        forever begin
            @(posedge clk_in); #1;
            if (rst_n_in && rd_valid_out) begin
                len = (rd_len_force != 0) ? rd_len_force : int'($urandom_range(4, 12));
                c = rev8(rd_msg_out[7:0]);
                rd_n_ss_in = 1'b0;
                for (int k = 0; k < len && rst_n_in; k++) begin
                    @(posedge clk_in); #1;
                    rd_sclk_in = ~rd_sclk_in;
                end
                rd_sclk_in = 1'b0; rd_n_ss_in = 1'b1;
                if (rst_n_in) begin
                    rd_byte_in = regfile[c[7:3]];
                    rd_valid_in = 1'b1;
                    @(posedge clk_in); #1;
                    rd_valid_in = 1'b0;
                    rd_byte_in = 8'($urandom);
                end
            end
        end
    end

    initial begin : mosi_noise
        wr_mosi_in = 1'b0; rd_mosi_in = 1'b0;
        forever begin
            @(posedge clk_in); #1;
            wr_mosi_in = 1'($urandom);
            rd_mosi_in = 1'($urandom);
        end
    end

    // Monitor: reference grant model, scoreboard pop on responses, pin and handshake checks.
    initial begin : monitor
        exp_t e;
        int win, last, since, wr_hi;
        logic [1:0] pv, pw;
        logic [9:0] pa;
        logic [15:0] pd;
        bit p_wrv, p_rdv, p_rdvin, p_done, pend, rd_sel, exp_busy;
        last = 1; since = 0; wr_hi = 0; pv = '0; pw = '0; pa = '0; pd = '0;
        p_wrv = 0; p_rdv = 0; p_rdvin = 0; p_done = 0; pend = 0;
        forever begin
            @(negedge clk_in);
            if (!rst_n_in) begin
                sb.delete(); last = 1; pv = '0; p_wrv = 0; p_rdv = 0;
                p_rdvin = 0; p_done = 0; pend = 0; wr_hi = 0;
                continue;
            end
            since++;
            exp_busy = (sb.size() != 0) || (req_ready_out != 2'b00);
            chk("busy", 32'(busy_out), 32'(exp_busy));
            if (wr_valid_out && rd_valid_out) begin
                errors++;
                $display("FAIL both_engine_valids actual=11 expected=not both t=%0t", $time);
            end
            rd_sel = rd_valid_out;
            if (req_ready_out != 2'b00) begin
                if (pv == 2'b00) begin
                    errors++;
                    $display("FAIL spurious_ready actual=%b expected=00", req_ready_out);
                end else begin
                    win = (pv == 2'b11) ? 1 - last : (pv[1] ? 1 : 0);
                    chk("grant", 32'(req_ready_out), (win == 1) ? 32'd2 : 32'd1);
                    if (pend) chk("grant_gap", 32'(since), 32'd2);
                    pend = 0;
                    e.idx   = win;
                    e.wr    = pw[win];
                    e.addr  = (win == 1) ? pa[9:5] : pa[4:0];
                    e.data  = (win == 1) ? pd[15:8] : pd[7:0];
                    e.err   = e.wr && wr_hang;
                    e.rdata = e.wr ? 8'h00 : regfile[e.addr];
                    sb.push_back(e);
                    last = win;
                    if (!e.wr) rd_sel = 1;
                end
            end
            chk("n_ss_mux", 32'(n_ss_out), 32'(wr_n_ss_in & rd_n_ss_in));
            chk("sclk_mux", 32'(sclk_out), 32'(wr_sclk_in | rd_sclk_in));
            chk("mosi_mux", 32'(mosi_out), 32'(rd_sel ? rd_mosi_in : wr_mosi_in));
            if (wr_valid_out && !p_wrv) begin
                last_wr_msg = wr_msg_out;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL wr_valid_no_txn actual=1 expected=0");
                end else begin
                    chk("wr_valid_for_write", 32'(sb[0].wr), 32'd1);
                    chk("wr_msg", 32'(wr_msg_out),
                        32'(int'(rev8(sb[0].data)) * 256 + int'(rev8(cmd_of(sb[0].addr, 1'b1)))));
                end
            end
            if (rd_valid_out && !p_rdv) begin
                last_rd_msg = rd_msg_out;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL rd_valid_no_txn actual=1 expected=0");
                end else begin
                    chk("rd_valid_for_read", 32'(sb[0].wr), 32'd0);
                    chk("rd_msg", 32'(rd_msg_out), 32'(rev8(cmd_of(sb[0].addr, 1'b0))));
                end
            end
            if (wr_valid_out) wr_hi++;
            if (!wr_valid_out && p_wrv) begin
                if (sb.size() != 0 && sb[0].err) chk("timeout_wr_valid_cycles", 32'(wr_hi), 32'(TO + 1));
                wr_hi = 0;
            end
            if (p_done)  chk("wr_valid_drop_after_done", 32'(wr_valid_out), 32'd0);
            if (p_rdvin) chk("rd_valid_drop_after_byte", 32'(rd_valid_out), 32'd0);
            if (resp_valid_out != 2'b00) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_resp actual=%b expected=none", resp_valid_out);
                end else begin
                    e = sb.pop_front();
                    chk("resp_valid", 32'(resp_valid_out), (e.idx == 1) ? 32'd2 : 32'd1);
                    chk("resp_data", 32'(resp_data_out), 32'(e.rdata));
                    chk("resp_err", 32'(resp_err_out), 32'(e.err));
                    last_resp_data = resp_data_out;
                end
                pend = (req_valid_in != 2'b00);
                since = 0;
            end
            pv = req_valid_in; pw = req_write_in; pa = req_addr_in; pd = req_data_in;
            p_wrv = wr_valid_out; p_rdv = rd_valid_out; p_rdvin = rd_valid_in; p_done = wr_done_in;
        end
    end

    task automatic step(output logic [1:0] got);
        @(posedge clk_in); #1;
        got = req_ready_out;
        req_valid_in = req_valid_in & ~got;
    endtask

    task automatic issue(input int i, input bit wr, input logic [4:0] a, input logic [7:0] d);
        req_write_in[i] = wr;
        if (i == 0) begin req_addr_in[4:0] = a; req_data_in[7:0] = d; end
        else begin req_addr_in[9:5] = a; req_data_in[15:8] = d; end
        req_valid_in[i] = 1'b1;
    endtask

    task automatic drain(input string name, input int budget);
        logic [1:0] g;
        int n;
        n = 0;
        while ((req_valid_in != 2'b00 || busy_out || sb.size() != 0) && n < budget) begin
            step(g); n++;
        end
        if (n >= budget) begin
            checks++; errors++;
            $display("FAIL %s drain_timeout actual=%0d cycles expected<%0d", name, n, budget);
        end
        step(g);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"},      32'(req_ready_out), 32'd0);
        chk({tag, "_resp_valid"}, 32'(resp_valid_out), 32'd0);
        chk({tag, "_resp_data"},  32'(resp_data_out), 32'd0);
        chk({tag, "_resp_err"},   32'(resp_err_out), 32'd0);
        chk({tag, "_wr_msg"},     32'(wr_msg_out), 32'd0);
        chk({tag, "_wr_valid"},   32'(wr_valid_out), 32'd0);
        chk({tag, "_rd_msg"},     32'(rd_msg_out), 32'd0);
        chk({tag, "_rd_valid"},   32'(rd_valid_out), 32'd0);
        chk({tag, "_busy"},       32'(busy_out), 32'd0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "simulation did not finish");
    end

    initial begin : main
        logic [1:0] g;
        int n, cnt, issued;
        rst_n_in = 1'b0; req_valid_in = '0; req_write_in = '0; req_addr_in = '0; req_data_in = '0;
        for (int i = 0; i < 32; i++) regfile[i] = 8'($urandom);
        regfile[5'h19] = 8'h3C;
        #2;
        check_reset_outputs("reset");
        repeat (3) @(posedge clk_in);
        #2; rst_n_in = 1'b1;

        // Single write and single read with known encodings.
        issue(0, 1'b1, 5'h11, 8'hA5);
        drain("single_write", 100);
        chk("wr_msg_0x11_a5", 32'(last_wr_msg), 32'h0000A551);
        issue(1, 1'b0, 5'h19, 8'h00);
        drain("single_read", 100);
        chk("rd_msg_0x19", 32'(last_rd_msg), 32'h00000013);
        chk("rd_data_0x19", 32'(last_resp_data), 32'h0000003C);

        // Both requesters continuously pending for four grants.
        issue(0, 1'b1, 5'($urandom), 8'($urandom));
        issue(1, 1'b0, 5'($urandom), 8'h00);
        n = 0; cnt = 0;
        while (n < 4 && cnt < 300) begin
            step(g); cnt++;
            for (int i = 0; i < 2; i++) if (g[i]) begin
                n++;
                if (n <= 2) issue(i, 1'($urandom), 5'($urandom), 8'($urandom));
            end
        end
        drain("alternate", 200);

        // Stuck write engine, then a normal write.
        wr_hang = 1'b1;
        issue(1, 1'b1, 5'($urandom), 8'($urandom));
        drain("timeout", 200);
        wr_hang = 1'b0;
        issue(0, 1'b1, 5'($urandom), 8'($urandom));
        drain("after_timeout", 100);

        // Back-to-back writes from req0 only.
        issue(0, 1'b1, 5'($urandom), 8'($urandom));
        n = 0; cnt = 0;
        while (n < 1 && cnt < 100) begin
            step(g); cnt++;
            if (g[0]) begin n++; issue(0, 1'b1, 5'($urandom), 8'($urandom)); end
        end
        drain("back_to_back", 200);

        // Random mixed traffic.
        issued = 0;
        for (int c = 0; c < 4000 && (issued < 40 || req_valid_in != 2'b00); c++) begin
            step(g);
            for (int i = 0; i < 2; i++)
                if (!req_valid_in[i] && issued < 40 && $urandom_range(0, 2) == 0) begin
                    issue(i, 1'($urandom), 5'($urandom), 8'($urandom));
                    issued++;
                end
        end
        drain("random", 500);

        // Reset in the middle of a read from req0.
        rd_len_force = 40;
        issue(0, 1'b0, 5'h07, 8'h00);
        n = 0; cnt = 0;
        while (cnt < 3 && n < 100) begin
            step(g); n++;
            if (rd_valid_out) cnt++;
        end
        if (cnt < 3) begin
            checks++; errors++;
            $display("FAIL mid_read_wait actual=%0d expected=3 rd_valid cycles", cnt);
        end
        #1; rst_n_in = 1'b0; #1;
        check_reset_outputs("mid_read_reset");
        req_valid_in = '0;
        repeat (3) step(g);
        rst_n_in = 1'b1;
        rd_len_force = 0;
        issue(0, 1'b1, 5'($urandom), 8'($urandom));
        issue(1, 1'b1, 5'($urandom), 8'($urandom));
        g = '0; n = 0;
        while (g == 2'b00 && n < 50) begin step(g); n++; end
        chk("post_reset_first_grant", 32'(g), 32'd1);
        drain("post_reset", 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
